// File: rtl/ex_pipe.sv
// Execute stage: add/sub/compare, logic ops, iterative shifter, flag register and
// branch resolution behind a valid/stall handshake, with one output register.
module ex_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned RA_WIDTH   = 4,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                v_i,
  input  logic                stall_i,
  output logic                stall_o,
  input  logic [3:0]          op_i,
  input  logic                immf_i,
  input  logic [WIDTH-1:0]    rd_value_i,
  input  logic [WIDTH-1:0]    rs_value_i,
  input  logic [WIDTH-1:0]    imm_value_i,
  input  logic [RA_WIDTH-1:0] rd_addr_i,
  input  logic [2:0]          cc_i,
  input  logic [PC_WIDTH-1:0] pc_value_i,
  output logic                v_o,
  output logic [WIDTH-1:0]    result_o,
  output logic [RA_WIDTH-1:0] rd_addr_o,
  output logic                wb_en_o,
  output logic                branch_en_o,
  output logic [PC_WIDTH-1:0] branch_addr_o,
  output logic [5:0]          flags_o
);

  localparam int unsigned SA_W  = $clog2(WIDTH);
  localparam int unsigned K_W   = SA_W + 1;
  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_BRR = 4'd8;
  localparam logic [3:0] OP_BRA = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  localparam int unsigned F_Z = 5;
  localparam int unsigned F_P = 4;
  localparam int unsigned F_N = 3;
  localparam int unsigned F_C = 2;
  localparam int unsigned F_V = 1;

  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [SA_W-1:0]     rem_q, rem_d;
  logic [1:0]          shop_q, shop_d;
  logic                shc_q, shc_d;
  logic [RA_WIDTH-1:0] shrd_q, shrd_d;
  logic                v_q, v_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [RA_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                wb_en_q, wb_en_d;
  logic                br_en_q, br_en_d;
  logic [PC_WIDTH-1:0] br_addr_q, br_addr_d;
  logic [5:0]          flags_q, flags_d;

  function automatic logic [5:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v);
    logic z;
    z = (r == '0);
    return {z, ~z & ~r[WIDTH-1], r[WIDTH-1], c, v, 1'b0};
  endfunction

  // Single-cycle datapath: adder, logic ops, branch condition and target.
  logic [WIDTH-1:0]    opr1, addend, alu_res;
  logic [SUM_W-1:0]    sum;
  logic                is_sub, alu_c, alu_v, taken;
  logic [PC_WIDTH-1:0] br_target;

  always_comb begin
    opr1    = immf_i ? imm_value_i : rs_value_i;
    is_sub  = (op_i == OP_SUB) || (op_i == OP_CMP);
    addend  = is_sub ? ~opr1 : opr1;
    sum     = {1'b0, rd_value_i} + {1'b0, addend} + SUM_W'(is_sub);
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    alu_v   = (rd_value_i[WIDTH-1] == addend[WIDTH-1]) &&
              (sum[WIDTH-1] != rd_value_i[WIDTH-1]);
    case (op_i)
      OP_AND: begin alu_res = rd_value_i & opr1; alu_c = 1'b0; alu_v = 1'b0; end
      OP_OR:  begin alu_res = rd_value_i | opr1; alu_c = 1'b0; alu_v = 1'b0; end
      OP_XOR: begin alu_res = rd_value_i ^ opr1; alu_c = 1'b0; alu_v = 1'b0; end
      default: ;
    endcase
    case (cc_i)
      3'd0:    taken = 1'b1;
      3'd1:    taken = flags_q[F_Z];
      3'd2:    taken = ~flags_q[F_Z];
      3'd3:    taken = flags_q[F_P];
      3'd4:    taken = flags_q[F_N];
      3'd5:    taken = flags_q[F_C];
      3'd6:    taken = flags_q[F_V];
      default: taken = 1'b0;
    endcase
    br_target = (op_i == OP_BRA) ? opr1[PC_WIDTH-1:0] : pc_value_i + opr1[PC_WIDTH-1:0];
  end

  // One shifter iteration; carry tracks the last bit pushed out.
  logic [K_W-1:0]   step_k;
  logic [WIDTH-1:0] step_res, l_out, r_out;
  logic             step_c;

  always_comb begin
    step_k = (K_W'(rem_q) > K_W'(SHIFT_STEP)) ? K_W'(SHIFT_STEP) : K_W'(rem_q);
    l_out  = sh_q >> (K_W'(WIDTH) - step_k);
    r_out  = sh_q >> (step_k - K_W'(1));
    case (shop_q)
      SH_SLL:  begin step_res = sh_q << step_k;            step_c = l_out[0]; end
      SH_SRA:  begin step_res = $signed(sh_q) >>> step_k;  step_c = r_out[0]; end
      default: begin step_res = sh_q >> step_k;            step_c = r_out[0]; end
    endcase
  end

  logic accept, out_free, is_shift;

  assign stall_o  = (state_q != S_IDLE) | (v_q & stall_i);
  assign accept   = v_i & ~stall_o;
  assign out_free = ~(v_q & stall_i);
  assign is_shift = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    rem_d     = rem_q;
    shop_d    = shop_q;
    shc_d     = shc_q;
    shrd_d    = shrd_q;
    v_d       = v_q;
    result_d  = result_q;
    rd_addr_d = rd_addr_q;
    wb_en_d   = wb_en_q;
    br_en_d   = br_en_q;
    br_addr_d = br_addr_q;
    flags_d   = flags_q;
    if (out_free) v_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && is_shift) begin
          state_d = S_SHIFT;
          sh_d    = rd_value_i;
          rem_d   = opr1[SA_W-1:0];
          shop_d  = op_i[1:0];
          shc_d   = 1'b0;
          shrd_d  = rd_addr_i;
        end else if (accept) begin
          v_d       = 1'b1;
          rd_addr_d = rd_addr_i;
          wb_en_d   = (op_i <= OP_XOR);
          br_en_d   = 1'b0;
          if ((op_i == OP_BRR) || (op_i == OP_BRA)) begin
            result_d  = WIDTH'(br_target);
            br_en_d   = taken;
            br_addr_d = br_target;
          end else if (op_i > OP_CMP) begin
            result_d = '0;
          end else begin
            result_d = alu_res;
            flags_d  = mk_flags(alu_res, alu_c, alu_v);
          end
        end
      end
      default: begin
        if (rem_q != '0) begin
          sh_d  = step_res;
          rem_d = rem_q - SA_W'(step_k);
          shc_d = step_c;
        end else if (out_free) begin
          v_d       = 1'b1;
          result_d  = sh_q;
          rd_addr_d = shrd_q;
          wb_en_d   = 1'b1;
          br_en_d   = 1'b0;
          flags_d   = mk_flags(sh_q, shc_q, 1'b0);
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      rem_q     <= '0;
      shop_q    <= '0;
      shc_q     <= 1'b0;
      shrd_q    <= '0;
      v_q       <= 1'b0;
      result_q  <= '0;
      rd_addr_q <= '0;
      wb_en_q   <= 1'b0;
      br_en_q   <= 1'b0;
      br_addr_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      shop_q    <= shop_d;
      shc_q     <= shc_d;
      shrd_q    <= shrd_d;
      v_q       <= v_d;
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      wb_en_q   <= wb_en_d;
      br_en_q   <= br_en_d;
      br_addr_q <= br_addr_d;
      flags_q   <= flags_d;
    end
  end

  assign v_o           = v_q;
  assign result_o      = result_q;
  assign rd_addr_o     = rd_addr_q;
  assign wb_en_o       = wb_en_q;
  assign branch_en_o   = br_en_q;
  assign branch_addr_o = br_addr_q;
  assign flags_o       = flags_q;

endmodule
